// File: rtl/instr_fetch.sv
// instr_fetch: PC owner, zero-latency ROM fetch into a 2-entry buffer with redirect and fault handling
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rom_addr,
    input  logic [31:0] instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);
    typedef enum logic [1:0] {S_BOOT, S_RUN, S_FAULT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    logic        head_q, head_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] instr_mem_q [2];
    logic [31:0] pc_mem_q [2];
    logic        pop, redir, bad_tgt, oor, fetch_en, push, enter_fault, tail;

    assign rom_addr    = {2'b00, pc_q[31:2]};
    assign if_valid    = count_q != 2'd0;
    assign if_instr    = instr_mem_q[head_q];
    assign if_pc       = pc_mem_q[head_q];
    assign fault       = fault_q;
    assign fault_pc    = fault_pc_q;
    assign fetch_count = fetch_count_q;

    // Fetch control: redirects beat the range check; FAULT ignores redirects and only drains
    always_comb begin
        pop           = if_valid & id_ready;
        redir         = redirect_valid & (state_q != S_FAULT);
        bad_tgt       = redir & (redirect_pc[1:0] != 2'b00);
        oor           = (state_q == S_RUN) & ({2'b00, pc_q[31:2]} >= IM_WORDS);
        fetch_en      = (state_q == S_RUN) & (!count_q[1] | pop);
        push          = fetch_en & !redir & !oor;
        enter_fault   = bad_tgt | (oor & !redir);
        tail          = head_q ^ count_q[0];
        state_d       = enter_fault ? S_FAULT : (redir | state_q == S_BOOT) ? S_RUN : state_q;
        pc_d          = (redir & !bad_tgt) ? redirect_pc : push ? pc_q + 32'd4 : pc_q;
        count_d       = redir ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
        head_d        = redir ? 1'b0 : head_q ^ pop;
        fault_d       = fault_q | enter_fault;
        fault_pc_d    = bad_tgt ? redirect_pc : enter_fault ? pc_q : fault_pc_q;
        fetch_count_d = fetch_count_q + {31'd0, push};
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_PC;
            count_q       <= 2'd0;
            head_q        <= 1'b0;
            fault_q       <= 1'b0;
            fault_pc_q    <= 32'd0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            count_q       <= count_d;
            head_q        <= head_d;
            fault_q       <= fault_d;
            fault_pc_q    <= fault_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Buffer storage: the tail slot takes {instr, pc} on every push
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_mem_q[0] <= 32'd0;
            instr_mem_q[1] <= 32'd0;
            pc_mem_q[0]    <= 32'd0;
            pc_mem_q[1]    <= 32'd0;
        end else if (push) begin
            instr_mem_q[tail] <= instr;
            pc_mem_q[tail]    <= pc_q;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenario tests for instr_fetch
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst, rst_b;
    logic [31:0] rom_addr, instr, redirect_pc, if_instr, if_pc, fault_pc, fetch_count;
    logic        redirect_valid, if_valid, id_ready, fault;
    logic [31:0] rom_addr_b, instr_b, if_instr_b, if_pc_b, fault_pc_b, fetch_count_b;
    logic        if_valid_b, id_ready_b, fault_b;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    assign instr   = 32'h1000_0000 + rom_addr;
    assign instr_b = 32'h1000_0000 + rom_addr_b;

    instr_fetch dut (
        .clk(clk), .rst(rst), .rom_addr(rom_addr), .instr(instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
        .fault(fault), .fault_pc(fault_pc), .fetch_count(fetch_count)
    );

    instr_fetch #(.IM_WORDS(4)) dut_b (
        .clk(clk), .rst(rst_b), .rom_addr(rom_addr_b), .instr(instr_b),
        .redirect_valid(1'b0), .redirect_pc(32'd0),
        .if_valid(if_valid_b), .if_instr(if_instr_b), .if_pc(if_pc_b), .id_ready(id_ready_b),
        .fault(fault_b), .fault_pc(fault_pc_b), .fetch_count(fetch_count_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called with rst held high for one edge; releases it and checks the startup timing
    task automatic boot_seq(input string tag);
        rst = 1'b0;
        tests++; if (rom_addr !== 32'd0) begin fails++; $display("FAIL %s boot rom_addr got %h exp 0", tag, rom_addr); end
        tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL %s boot if_valid got %b exp 0", tag, if_valid); end
        step();
        tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL %s cyc1 if_valid got %b exp 0", tag, if_valid); end
        step();
        tests++; if (if_valid !== 1'b1) begin fails++; $display("FAIL %s cyc2 if_valid got %b exp 1", tag, if_valid); end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step();
            tests++;
            if (if_pc !== 32'(4 * k) || if_instr !== 32'h1000_0000 + 32'(k) || fetch_count !== 32'(k + 1)) begin
                fails++;
                $display("FAIL %s seq%0d got pc=%h instr=%h cnt=%0d exp pc=%h instr=%h cnt=%0d",
                         tag, k, if_pc, if_instr, fetch_count, 4 * k, 32'h1000_0000 + 32'(k), k + 1);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
        step(); step();
        tests++;
        if (if_valid !== 1'b0 || fault !== 1'b0 || fault_pc !== 32'd0 || fetch_count !== 32'd0 ||
            if_instr !== 32'd0 || if_pc !== 32'd0 || rom_addr !== 32'd0) begin
            fails++;
            $display("FAIL reset_vals got v=%b f=%b fpc=%h cnt=%0d instr=%h pc=%h ra=%h exp all 0",
                     if_valid, fault, fault_pc, fetch_count, if_instr, if_pc, rom_addr);
        end
        boot_seq("reset");
    endtask

    task automatic test_stall();
        rst = 1'b1; id_ready = 1'b0;
        step();
        rst = 1'b0;
        step(); step(); step(); step(); step(); step(); step();
        tests++;
        if (if_valid !== 1'b1 || if_pc !== 32'd0 || if_instr !== 32'h1000_0000 || rom_addr !== 32'd2 || fetch_count !== 32'd2) begin
            fails++;
            $display("FAIL stall_hold got v=%b pc=%h instr=%h ra=%h cnt=%0d exp v=1 pc=0 instr=10000000 ra=2 cnt=2",
                     if_valid, if_pc, if_instr, rom_addr, fetch_count);
        end
        id_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            tests++;
            if (if_valid !== 1'b1 || if_pc !== 32'(4 * k)) begin
                fails++;
                $display("FAIL stall_release%0d got v=%b pc=%h exp v=1 pc=%h", k, if_valid, if_pc, 4 * k);
            end
        end
    endtask

    task automatic test_redirect_full();
        rst = 1'b1; id_ready = 1'b0;
        step();
        rst = 1'b0;
        step(); step(); step();
        tests++;
        if (if_valid !== 1'b1 || if_pc !== 32'd0 || rom_addr !== 32'd2) begin
            fails++;
            $display("FAIL redir_setup got v=%b pc=%h ra=%h exp v=1 pc=0 ra=2", if_valid, if_pc, rom_addr);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h40; id_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        tests++;
        if (if_valid !== 1'b0 || rom_addr !== 32'h10 || fetch_count !== 32'd2) begin
            fails++;
            $display("FAIL redir_flush got v=%b ra=%h cnt=%0d exp v=0 ra=10 cnt=2", if_valid, rom_addr, fetch_count);
        end
        step();
        tests++;
        if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== 32'h1000_0010 || fetch_count !== 32'd3) begin
            fails++;
            $display("FAIL redir_target got v=%b pc=%h instr=%h cnt=%0d exp v=1 pc=40 instr=10000010 cnt=3",
                     if_valid, if_pc, if_instr, fetch_count);
        end
    endtask

    task automatic test_misaligned();
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        step();
        redirect_valid = 1'b0;
        tests++;
        if (fault !== 1'b1 || fault_pc !== 32'h42 || if_valid !== 1'b0 || fetch_count !== 32'd3 || rom_addr !== 32'h11) begin
            fails++;
            $display("FAIL misalign_entry got f=%b fpc=%h v=%b cnt=%0d ra=%h exp f=1 fpc=42 v=0 cnt=3 ra=11",
                     fault, fault_pc, if_valid, fetch_count, rom_addr);
        end
        step(); step(); step();
        tests++;
        if (if_valid !== 1'b0 || fetch_count !== 32'd3) begin
            fails++;
            $display("FAIL misalign_frozen got v=%b cnt=%0d exp v=0 cnt=3", if_valid, fetch_count);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        step();
        redirect_valid = 1'b0;
        step();
        tests++;
        if (fault !== 1'b1 || fault_pc !== 32'h42 || rom_addr !== 32'h11 || if_valid !== 1'b0 || fetch_count !== 32'd3) begin
            fails++;
            $display("FAIL fault_ignore_redir got f=%b fpc=%h ra=%h v=%b cnt=%0d exp f=1 fpc=42 ra=11 v=0 cnt=3",
                     fault, fault_pc, rom_addr, if_valid, fetch_count);
        end
    endtask

    task automatic test_reset_in_fault();
        rst = 1'b1; id_ready = 1'b1;
        step();
        tests++;
        if (fault !== 1'b0 || fault_pc !== 32'd0 || fetch_count !== 32'd0 || if_valid !== 1'b0) begin
            fails++;
            $display("FAIL fault_reset got f=%b fpc=%h cnt=%0d v=%b exp all 0", fault, fault_pc, fetch_count, if_valid);
        end
        boot_seq("refetch");
    endtask

    task automatic test_out_of_range();
        rst_b = 1'b1; id_ready_b = 1'b1;
        step();
        rst_b = 1'b0;
        step(); step();
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            tests++;
            if (if_valid_b !== 1'b1 || if_pc_b !== 32'(4 * k) || fault_b !== 1'b0) begin
                fails++;
                $display("FAIL oor_seq%0d got v=%b pc=%h f=%b exp v=1 pc=%h f=0", k, if_valid_b, if_pc_b, fault_b, 4 * k);
            end
        end
        step();
        tests++;
        if (fault_b !== 1'b1 || fault_pc_b !== 32'h10 || fetch_count_b !== 32'd4 || if_valid_b !== 1'b0) begin
            fails++;
            $display("FAIL oor_fault got f=%b fpc=%h cnt=%0d v=%b exp f=1 fpc=10 cnt=4 v=0",
                     fault_b, fault_pc_b, fetch_count_b, if_valid_b);
        end
        step(); step();
        tests++;
        if (fetch_count_b !== 32'd4 || fault_pc_b !== 32'h10) begin
            fails++;
            $display("FAIL oor_frozen got cnt=%0d fpc=%h exp cnt=4 fpc=10", fetch_count_b, fault_pc_b);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rst_b = 1'b1; id_ready = 1'b0; id_ready_b = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'd0;
        test_reset();
        test_stall();
        test_redirect_full();
        test_misaligned();
        test_reset_in_fault();
        test_out_of_range();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch front end for the single-cycle CPU. It owns the program counter and drives the word address into the asynchronous instruction ROM (dist_mem_im). It captures the returned instruction word together with its PC into a 2-entry buffer. It hands entries to decode over a valid/ready handshake and handles branch/jump redirects, stalls, and fetch faults.

Parameters:
RESET_PC, 32'h0000_0000, byte address of the first fetch after reset; must be word aligned.
IM_WORDS, 1024, number of 32-bit words in the instruction ROM; word index >= IM_WORDS is out of range.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
rom_addr  output  32  word address to instruction ROM = {2'b00, pc[31:2]}
instr  input  32  ROM read data, combinational from rom_addr, valid in the same cycle
redirect_valid  input  1  branch/jump taken this cycle
redirect_pc  input  32  byte target address for the redirect
if_valid  output  1  buffer head holds a valid instruction
if_instr  output  32  instruction at buffer head
if_pc  output  32  byte PC of buffer head
id_ready  input  1  decode accepts the head this cycle
fault  output  1  sticky fetch fault flag
fault_pc  output  32  offending byte address, captured on fault entry
fetch_count  output  32  number of instructions pushed into the buffer since reset

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). rst has priority over every other input in that cycle.
- Reset values: pc=RESET_PC, state=BOOT, count=0, if_valid=0, if_instr=0, if_pc=0, fault=0, fault_pc=0, fetch_count=0.
- rom_addr is combinational from the pc register. instr is sampled in the same cycle (zero-latency ROM).
- FSM states:
  - BOOT: one cycle; no fetch; next state RUN.
  - RUN: fetching.
  - FAULT: no fetch, no push; buffer drains normally via the handshake; exit only via rst.
- pop = if_valid & id_ready.
- fetch_en = (state==RUN) & (count<2 | pop).
- Out-of-range check in RUN: if pc[31:2] >= IM_WORDS and no redirect this cycle:
  - no push;
  - next state FAULT; fault<=1; fault_pc<=pc.
- Normal push when fetch_en, no redirect, and pc in range:
  - write {instr, pc} at tail; pc<=pc+4 (mod 2^32);
  - fetch_count<=fetch_count+1 (wraps).
- Stall: when count==2 and !pop, pc holds and no push occurs. Push and pop in the same cycle at count==2 is legal and leaves count=2.
- Buffer: 2 entries, FIFO order. if_valid=(count!=0); if_instr/if_pc show the head. Head outputs are stable while if_valid & !id_ready.
- Redirect (redirect_valid=1 in RUN or BOOT):
  - a pop in the same cycle is a completed transfer;
  - no push that cycle; all entries are flushed, so count=0 next cycle;
  - if redirect_pc[1:0]==0: pc<=redirect_pc, state RUN;
  - else: state FAULT, fault<=1, fault_pc<=redirect_pc, pc unchanged.
- Redirect in FAULT is ignored (no flush, no fault_pc change).
- Redirect overrides the out-of-range check in the same cycle. The new target is range-checked on the following cycle.
- fault_pc captures only on the FAULT entry transition. It does not change while in FAULT.
- Reset mid-operation: buffer contents discarded, if_valid=0 on the next cycle, fetch resumes from RESET_PC after BOOT.

Test Plan:
- Reset then id_ready=1, ROM word k = 32'h1000_0000+k:
  - rom_addr=0 during BOOT;
  - if_valid rises on cycle 2 after reset release;
  - sequence (if_pc, if_instr) = (0, 32'h1000_0000), (4, 32'h1000_0001), (8, 32'h1000_0002), … one per cycle;
  - fetch_count increments by 1 each cycle.
- Stall: hold id_ready=0 for 5 cycles after first push:
  - count saturates at 2, pc holds at 8, head stays if_pc=0;
  - on release, order 0, 4, 8 is delivered with no duplicates or gaps.
- Redirect while buffer full: redirect_valid=1, redirect_pc=32'h40, id_ready=1:
  - head transferred that cycle;
  - next cycle if_valid=0, rom_addr=32'h10;
  - following cycle if_pc=32'h40.
- Misaligned redirect: redirect_pc=32'h42:
  - fault=1, fault_pc=32'h42 next cycle;
  - if_valid=0; no further pushes; fetch_count frozen;
  - a later redirect to 32'h0 is ignored.
- Out of range: IM_WORDS=4, id_ready=1:
  - entries 0, 4, 8, 12 delivered;
  - when pc=16: fault=1, fault_pc=32'h10, fetch_count=4.
- Reset during FAULT: assert rst for 1 cycle:
  - fault=0, fault_pc=0, fetch_count=0;
  - fetch restarts at RESET_PC with the same timing as the first scenario.
